// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns one M-stage load/store into a single
// held memory request, stalling the pipeline until ack or a wait-cycle timeout.
module dm_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Last counter value tolerated before the timeout fires (counter starts at 0).
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] rd_data_reg, rd_data_next;
    logic        err_reg, err_next;
    logic        we_reg;
    logic [29:0] addr_reg;
    logic [3:0]  byteen_reg;
    logic [31:0] wdata_reg;
    logic        live;
    logic        latch_en;
    logic        in_wait;
    logic        unused_addr_bits;

    // A store with no lanes enabled is a no-op and must not touch memory.
    assign live = req_valid && !(req_we && (req_byteen == 4'b0000));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        rd_data_next  = rd_data_reg;
        err_next      = err_reg;
        latch_en      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (live) begin
                    latch_en      = 1'b1;
                    wait_cnt_next = 8'd0;
                    err_next      = 1'b0;
                    rd_data_next  = 32'd0;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rd_data_next = we_reg ? 32'd0 : mem_rdata;
                    err_next     = 1'b0;
                    state_next   = DONE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    rd_data_next = 32'd0;
                    err_next     = 1'b1;
                    state_next   = DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            DONE: begin
                // The request is still presented here; it is deliberately not reissued.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 8'd0;
            rd_data_reg  <= 32'd0;
            err_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 30'd0;
            byteen_reg   <= 4'b0000;
            wdata_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            rd_data_reg  <= rd_data_next;
            err_reg      <= err_next;
            if (latch_en) begin
                we_reg     <= req_we;
                addr_reg   <= req_addr[31:2];
                byteen_reg <= req_we ? req_byteen : 4'b0000;
                wdata_reg  <= req_wdata;
            end
        end
    end

    assign in_wait = (state_reg == WAIT);

    // Stall is combinational in IDLE so the issuing instruction freezes the same cycle.
    assign stall    = !reset && ((state_reg == IDLE && live) || in_wait);
    assign rd_valid = (state_reg == DONE);
    assign err      = (state_reg == DONE) && err_reg;
    assign rd_data  = rd_data_reg;

    assign mem_req   = in_wait;
    assign mem_we    = in_wait && we_reg;
    assign mem_addr  = {addr_reg, 2'b00};
    assign mem_wdata = wdata_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_byteen[gi] = in_wait && byteen_reg[gi];
        end
    endgenerate

    // Sub-word offset is expressed only through the byte enables.
    assign unused_addr_bits = ^req_addr[1:0];

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: expected completions are queued at issue
// and compared when rd_valid fires; a second instance uses a short timeout.
module tb_dm_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid, req_valid_to;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        stall, rd_valid, err, mem_req, mem_we;
    logic [31:0] rd_data, mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;

    logic        stall_to, rd_valid_to, err_to, mem_req_to, mem_we_to;
    logic [31:0] rd_data_to, mem_addr_to, mem_wdata_to;
    logic [3:0]  mem_byteen_to;

    int total = 0;
    int bad   = 0;
    int txn_n = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       tag;
    } exp_t;
    exp_t sb[$];

    dm_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_wdata(req_wdata),
        .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    dm_access_ctrl #(.TIMEOUT(3)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_to), .req_we(req_we), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_wdata(req_wdata),
        .stall(stall_to), .rd_valid(rd_valid_to), .rd_data(rd_data_to), .err(err_to),
        .mem_req(mem_req_to), .mem_we(mem_we_to), .mem_addr(mem_addr_to),
        .mem_byteen(mem_byteen_to), .mem_wdata(mem_wdata_to),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got_data, input logic got_err);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_rd_data"}, got_data, e.data);
            chk({e.tag, "_err"}, {31'd0, got_err}, {31'd0, e.err});
            txn_n++;
            $display("txn %0d %s: rd_data=%h err=%b", txn_n, e.tag, got_data, got_err);
        end
    endtask

    // Issue one transaction on the default instance; ack arrives on WAIT cycle ack_cyc (0-based).
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int ack_cyc, input logic [31:0] rdata,
                          input string tag);
        exp_t e;
        logic [31:0] exp_addr;
        exp_addr   = {addr[31:2], 2'b00};
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_byteen = be;
        req_wdata  = wd;
        e.data = we ? 32'd0 : rdata;
        e.err  = 1'b0;
        e.tag  = tag;
        sb.push_back(e);
        #1 chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
        for (int c = 0; c <= ack_cyc; c++) begin
            @(negedge clk);
            chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
            chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
            chk({tag, "_mem_addr"}, mem_addr, exp_addr);
            chk({tag, "_mem_byteen"}, {28'd0, mem_byteen}, {28'd0, (we ? be : 4'b0000)});
            chk({tag, "_mem_wdata"}, mem_wdata, wd);
            chk({tag, "_no_early_valid"}, {31'd0, rd_valid}, 32'd0);
            mem_ack   = (c == ack_cyc);
            mem_rdata = (c == ack_cyc) ? rdata : $urandom;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_mem_req_done"}, {31'd0, mem_req}, 32'd0);
        pop_check(tag, rd_data, err);
        @(negedge clk);
        chk({tag, "_no_reissue"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_idle_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_idle_byteen"}, {28'd0, mem_byteen}, 32'd0);
        chk({tag, "_valid_pulse"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_err_idle"}, {31'd0, err}, 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        reset        = 1'b1;
        req_valid    = 1'b1;
        req_valid_to = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'h0000_0100;
        req_byteen   = 4'b1111;
        req_wdata    = 32'd0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'd0;

        // Reset holds everything quiet even with a live request presented.
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_byteen", {28'd0, mem_byteen}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 32'h0000_1006, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF, "load_imm");
        do_txn(1'b1, 32'h0000_2002, 4'b0100, 32'h00AB_0000, 3, 32'h1234_5678, "store_ack4");

        // Zero-lane store: no transaction, no stall.
        req_valid = 1'b1; req_we = 1'b1; req_byteen = 4'b0000; req_addr = 32'h0000_3000;
        #1 chk("nolane_stall", {31'd0, stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nolane_mem_req", {31'd0, mem_req}, 32'd0);
            chk("nolane_rd_valid", {31'd0, rd_valid}, 32'd0);
        end
        req_valid = 1'b0;

        // Stray ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_valid", {31'd0, rd_valid}, 32'd0);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);

        // Back-to-back loads.
        do_txn(1'b0, 32'h0000_5000, 4'b1111, 32'h0, 0, 32'h1111_2222, "b2b_a");
        do_txn(1'b0, 32'h0000_5004, 4'b0011, 32'h0, 0, 32'h3333_4444, "b2b_b");
        @(negedge clk);

        // Short-timeout instance: abort after three WAIT cycles.
        req_valid_to = 1'b1; req_we = 1'b0; req_addr = 32'h0000_3008; req_byteen = 4'b1111;
        e.data = 32'd0; e.err = 1'b1; e.tag = "timeout"; sb.push_back(e);
        #1 chk("to_stall_idle", {31'd0, stall_to}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rdata = $urandom | 32'h1;
            chk("to_mem_req", {31'd0, mem_req_to}, 32'd1);
            chk("to_no_early_valid", {31'd0, rd_valid_to}, 32'd0);
        end
        @(negedge clk);
        chk("to_rd_valid", {31'd0, rd_valid_to}, 32'd1);
        chk("to_stall_done", {31'd0, stall_to}, 32'd0);
        chk("to_mem_req_done", {31'd0, mem_req_to}, 32'd0);
        pop_check("timeout", rd_data_to, err_to);
        @(negedge clk);
        chk("to_err_pulse", {31'd0, err_to}, 32'd0);
        chk("to_no_reissue", {31'd0, mem_req_to}, 32'd0);
        req_valid_to = 1'b0;
        @(negedge clk);

        // Ack on the cycle the timeout would fire: ack wins.
        req_valid_to = 1'b1;
        e.data = 32'hCAFE_F00D; e.err = 1'b0; e.tag = "ack_wins"; sb.push_back(e);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("aw_mem_req", {31'd0, mem_req_to}, 32'd1);
            mem_ack   = (c == 2);
            mem_rdata = (c == 2) ? 32'hCAFE_F00D : $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk("aw_rd_valid", {31'd0, rd_valid_to}, 32'd1);
        pop_check("ack_wins", rd_data_to, err_to);
        req_valid_to = 1'b0;
        @(negedge clk);

        // Reset mid-WAIT drops the request at once; no completion ever appears.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000; req_byteen = 4'b1111;
        @(negedge clk);
        chk("rw_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rw_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rw_stall_drop", {31'd0, stall}, 32'd0);
        chk("rw_no_valid", {31'd0, rd_valid}, 32'd0);
        @(negedge clk);
        chk("rw_hold_req", {31'd0, mem_req}, 32'd0);
        chk("rw_hold_valid", {31'd0, rd_valid}, 32'd0);
        reset = 1'b0;
        do_txn(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 1, 32'h0BAD_F00D, "post_reset");

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
